seg_bcd_scan: RTL and testbench



---
 rtl/seg_pkg.sv | 51 +++++
 rtl/bcd_dabble.sv | 61 ++++++
 rtl/seg_bcd_scan.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_bcd_scan.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment BCD driver: digit/segment codes,
// conversion FSM states and the decimal limit helper.
package seg_pkg;

  localparam logic [3:0] SEG_MINUS = 4'd10;
  localparam logic [3:0] SEG_BLANK = 4'd11;

  localparam logic [7:0] SEG_CODE_MINUS = 8'hBF;
  localparam logic [7:0] SEG_CODE_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Active-low g..a patterns; MINUS is g only, anything else is dark.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:      g = 7'h40;
      4'd1:      g = 7'h79;
      4'd2:      g = 7'h24;
      4'd3:      g = 7'h30;
      4'd4:      g = 7'h19;
      4'd5:      g = 7'h12;
      4'd6:      g = 7'h02;
      4'd7:      g = 7'h78;
      4'd8:      g = 7'h00;
      4'd9:      g = 7'h10;
      SEG_MINUS: g = 7'h3F;
      default:   g = 7'h7F;
    endcase
    return g;
  endfunction

  // Full segment byte; the decimal point is only honoured on numeric codes.
  function automatic logic [7:0] seg_encode(input logic [3:0] code, input logic dp);
    logic dp_n;
    dp_n = (code <= 4'd9) ? ~dp : 1'b1;
    return {dp_n, seg7(code)};
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Sequential double-dabble: one shift-and-adjust iteration per clock, DATA_W
// iterations after start, then a one-cycle done pulse with the BCD result held.
module bcd_dabble #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin;
  logic [CNT_W-1:0]  cnt;
  logic              active;
  logic [BCD_W-1:0]  bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt    <= '0;
        active <= 1'b1;
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  // Datapath: the adjust and the shift happen in the same clock.
  always_ff @(posedge clk) begin
    if (start) begin
      bin <= din;
      bcd <= '0;
    end else if (active) begin
      bcd <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
      bin <= {bin[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seg_bcd_scan.sv
// Multiplexed 7-segment driver: valid/busy load, BCD conversion, blanking/sign/
// overflow framing and digit scan. Optional digit blinking under SEG_BLINK_EN.
module seg_bcd_scan
  import seg_pkg::*;
#(
  parameter int DATA_W    = 20,
  parameter int DIGITS    = 6,
  parameter int SCAN_CNT  = 50000,
  parameter int BLINK_CNT = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              sign,
  input  logic [DIGITS-1:0] point,
  input  logic [DIGITS-1:0] blink,
  input  logic              data_vld,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          IDX_W   = $clog2(DIGITS);
  localparam int          SCAN_W  = $clog2(SCAN_CNT + 1);
  localparam logic [63:0] MAX_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MAX_NEG = pow10(DIGITS - 1) - 64'd1;

  state_t            state;
  logic              pend;
  logic [DATA_W-1:0] hold_data;
  logic              hold_sign;
  logic [DIGITS-1:0] hold_point;

  logic              start;
  logic [DATA_W-1:0] st_data;
  logic              st_sign;
  logic [DIGITS-1:0] st_point;
  logic              st_ovf;

  logic              cur_sign;
  logic [DIGITS-1:0] cur_point;
  logic              cur_ovf;

  logic [BCD_W-1:0]  bcd;
  logic              dab_done;

  logic [DIGITS-1:0][3:0] frame, frame_nxt;
  logic [DIGITS-1:0]      dp, dp_nxt;

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic              blink_off;

  // Load source: live inputs win over the held request when both exist.
  always_comb begin
    start    = 1'b0;
    st_data  = data;
    st_sign  = sign;
    st_point = point;
    case (state)
      ST_IDLE:   start = data_vld;
      ST_COMMIT: begin
        if (data_vld) begin
          start = 1'b1;
        end else if (pend) begin
          start    = 1'b1;
          st_data  = hold_data;
          st_sign  = hold_sign;
          st_point = hold_point;
        end
      end
      default:   start = 1'b0;
    endcase
    st_ovf = 64'(st_data) > (st_sign ? MAX_NEG : MAX_POS);
  end

  bcd_dabble #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (st_data),
    .bcd   (bcd),
    .done  (dab_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pend  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (data_vld) begin
            state <= ST_CONV;
            busy  <= 1'b1;
          end
        end
        ST_CONV: begin
          if (data_vld) pend <= 1'b1;
          if (dab_done) begin
            state <= ST_COMMIT;
            done  <= 1'b1;
            ovf   <= cur_ovf;
            busy  <= pend | data_vld;
          end
        end
        ST_COMMIT: begin
          if (start) begin
            state <= ST_CONV;
            busy  <= 1'b1;
            pend  <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CONV && data_vld) begin
      hold_data  <= data;
      hold_sign  <= sign;
      hold_point <= point;
    end
    if (start) begin
      cur_sign  <= st_sign;
      cur_point <= st_point;
      cur_ovf   <= st_ovf;
    end
  end

  // Frame build: the highest significant digit or lit point sets the visible width.
  always_comb begin
    int msd;
    int pmax;
    int top;
    msd  = 0;
    pmax = 0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
      if (cur_point[i]) pmax = i;
    end
    top = (msd > pmax) ? msd : pmax;
    for (int i = 0; i < DIGITS; i++) begin
      dp_nxt[i] = 1'b0;
      if (cur_ovf) begin
        frame_nxt[i] = SEG_MINUS;
      end else if (i <= top) begin
        frame_nxt[i] = bcd[4*i +: 4];
        dp_nxt[i]    = cur_point[i];
      end else if (cur_sign && i == top + 1) begin
        frame_nxt[i] = SEG_MINUS;
      end else begin
        frame_nxt[i] = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) frame[i] <= (i == 0) ? 4'd0 : SEG_BLANK;
      dp <= '0;
    end else if (state == ST_CONV && dab_done) begin
      frame <= frame_nxt;
      dp    <= dp_nxt;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CNT + 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_CNT - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign blink_off = blink_phase & blink[idx];
`else
  localparam int unused_blink_cnt = BLINK_CNT;
  logic unused_blink;
  assign unused_blink = ^blink;
  assign blink_off    = 1'b0;
`endif

  // Scan: sel and seg are both registered from the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      sel      <= '0;
      seg      <= SEG_CODE_BLANK;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_CNT - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      sel <= DIGITS'(1) << idx;
      seg <= blink_off ? SEG_CODE_BLANK : seg_encode(frame[idx], dp[idx]);
    end
  end

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Scoreboard bench for seg_bcd_scan: expected frames are queued at issue and
// checked against the scanned seg/sel outputs after each done pulse.
module tb_seg_bcd_scan;

  localparam int DATA_W    = 20;
  localparam int DIGITS    = 6;
  localparam int SCAN_CNT  = 4;
  localparam int BLINK_CNT = 16;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [DIGITS-1:0][7:0] segs;
    bit                     ovf;
    int                     lat_ref;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              sign = 1'b0;
  logic [DIGITS-1:0] point = '0;
  logic [DIGITS-1:0] blink = '0;
  logic              data_vld = 1'b0;
  logic              busy, done, ovf;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  exp_t exp_q[$];
  logic [DIGITS-1:0] blink_q = '0;

  seg_bcd_scan #(
    .DATA_W    (DATA_W),
    .DIGITS    (DIGITS),
    .SCAN_CNT  (SCAN_CNT),
    .BLINK_CNT (BLINK_CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .sign     (sign),
    .point    (point),
    .blink    (blink),
    .data_vld (data_vld),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .sel      (sel),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_cyc <= 0;
      blink_q <= '0;
    end else begin
      rel_cyc <= rel_cyc + 1;
      blink_q <= blink;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t reset_frame();
    exp_t e;
    for (int i = 0; i < DIGITS; i++) e.segs[i] = (i == 0) ? 8'hC0 : 8'hFF;
    e.ovf     = 1'b0;
    e.lat_ref = -1;
    return e;
  endfunction

  // Reference: decimal digits by division, width from magnitude and points.
  function automatic exp_t model(input int unsigned v, input bit s, input logic [DIGITS-1:0] p);
    exp_t            e;
    longint unsigned lim, pw;
    int              msd, pm, top, d;
    lim = 1;
    for (int i = 0; i < (s ? DIGITS - 1 : DIGITS); i++) lim = lim * 10;
    lim       = lim - 1;
    e.ovf     = (longint'(v) > lim);
    e.lat_ref = -1;
    msd = 0;
    pw  = 10;
    while (longint'(v) >= pw) begin
      msd++;
      pw = pw * 10;
    end
    pm = 0;
    for (int i = 0; i < DIGITS; i++) if (p[i]) pm = i;
    top = (msd > pm) ? msd : pm;
    pw  = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d  = int'((longint'(v) / pw) % 10);
      pw = pw * 10;
      if (e.ovf)                   e.segs[i] = 8'hBF;
      else if (i <= top)           e.segs[i] = p[i] ? (SEG_TAB[d] & 8'h7F) : SEG_TAB[d];
      else if (s && i == top + 1)  e.segs[i] = 8'hBF;
      else                         e.segs[i] = 8'hFF;
    end
    return e;
  endfunction

  // Called at a negedge; the following posedge samples the request.
  task automatic issue(input int unsigned v, input bit s, input logic [DIGITS-1:0] p,
                       input bit replace, input bit chk_lat);
    exp_t e;
    e = model(v, s, p);
    e.lat_ref = chk_lat ? cyc + 1 : -1;
    if (replace && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(e);
    data     = DATA_W'(v);
    sign     = s;
    point    = p;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    if (chk_lat) chk("busy_after_load", busy, 1'b1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"},  sel,  '0);
    chk({tag, "_seg"},  seg,  8'hFF);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"},  ovf,  1'b0);
  endtask

  // Monitor: scan order, displayed segments, and done-time ovf/latency.
  initial begin
    exp_t cur, nxt;
    bit   have_nxt;
    int   ei;
    logic [7:0] es;
    cur      = reset_frame();
    have_nxt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || rel_cyc == 0) begin
        if (!rst_n) begin
          cur      = reset_frame();
          have_nxt = 1'b0;
        end
      end else begin
        if (have_nxt) begin
          cur      = nxt;
          have_nxt = 1'b0;
        end
        ei = ((rel_cyc - 1) / SCAN_CNT) % DIGITS;
        chk("sel_scan", sel, DIGITS'(1) << ei);
        es = cur.segs[ei];
`ifdef SEG_BLINK_EN
        if ((((rel_cyc - 1) / BLINK_CNT) % 2) == 1 && blink_q[ei]) es = 8'hFF;
`endif
        chk($sformatf("seg_digit%0d", ei), seg, es);
        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
          end else begin
            nxt      = exp_q.pop_front();
            have_nxt = 1'b1;
            chk("ovf_at_done", ovf, nxt.ovf);
            if (nxt.lat_ref >= 0) chk("done_latency", cyc - nxt.lat_ref, DATA_W + 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned v;
    bit          s;
    logic [DIGITS-1:0] p;
    localparam int SETTLE = DATA_W + 2 + DIGITS * SCAN_CNT + 4;

    wait_cyc(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(30);

    issue(123456, 1'b0, 6'b000000, 1'b0, 1'b1); wait_cyc(SETTLE);
    issue(42,     1'b1, 6'b000000, 1'b0, 1'b1); wait_cyc(SETTLE);
    issue(5,      1'b0, 6'b000010, 1'b0, 1'b1); wait_cyc(SETTLE);
    issue(100000, 1'b1, 6'b000000, 1'b0, 1'b1); wait_cyc(SETTLE);

    // Abort mid-conversion: the queued frame is discarded along with the request.
    issue(999, 1'b0, 6'b000000, 1'b0, 1'b1);
    wait_cyc(5);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    exp_q.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(30);

    issue(7, 1'b0, 6'b000000, 1'b0, 1'b1); wait_cyc(SETTLE);

    issue(11, 1'b0, 6'b000000, 1'b0, 1'b1);
    wait_cyc(3);
    issue(22, 1'b0, 6'b000000, 1'b0, 1'b0);
    wait_cyc(3);
    issue(33, 1'b0, 6'b000000, 1'b1, 1'b0);
    wait_cyc(2 * SETTLE);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 999999);
        2:       begin
                   case ($urandom_range(0, 3))
                     0:       v = 99999;
                     1:       v = 100000;
                     2:       v = 999999;
                     default: v = 1000000;
                   endcase
                 end
        default: v = $urandom_range(0, (1 << DATA_W) - 1);
      endcase
      s = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 1) == 1) ? DIGITS'($urandom) : '0;
`ifdef SEG_BLINK_EN
      blink = DIGITS'($urandom);
`endif
      issue(v, s, p, 1'b0, 1'b1);
      wait_cyc(SETTLE);
    end

    chk("frames_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
